// File: rtl/nn_mac_pkg.sv
// Shared types for the pixel/weight MAC datapath: widths, word typedefs and the
// sequencer state encoding.
package nn_mac_pkg;

    localparam int WEIGHT_W = 12;
    localparam int ACC_W    = 19;

    typedef logic [WEIGHT_W-1:0] weight_t;
    typedef logic [ACC_W-1:0]    acc_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } seq_state_t;

    // Counter/address width for a range of n values, never narrower than one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_weight_sequencer_if.sv
// Bundle of the sequencer's job, weight-memory, multiplier and result signals.
// master = sequencer side, slave = environment (controller, memory, MAC).
interface pixel_weight_sequencer_if
    import nn_mac_pkg::*;
#(
    parameter int N_INPUTS = 16,
    parameter int WEIGHT_W = nn_mac_pkg::WEIGHT_W,
    parameter int ACC_W    = nn_mac_pkg::ACC_W
);
    localparam int ADDR_W = addr_width(N_INPUTS);

    // Handshakes: a transfer happens in every cycle where valid && ready are both
    // high at the rising edge; the source holds its payload steady until then.
    logic                start_valid;
    logic                start_ready;
    logic [N_INPUTS-1:0] pixel_vec;

    logic                weight_rd_en;
    logic [ADDR_W-1:0]   weight_addr;
    logic [WEIGHT_W-1:0] weight_data;

    logic [WEIGHT_W-1:0] WeightPort;
    logic                PixelPort;
    logic                mac_clear;
    logic                mac_en;
    logic [ACC_W-1:0]    Output_syn;

    logic                result_valid;
    logic                result_ready;
    logic [ACC_W-1:0]    result_data;
    logic                busy;

    modport master (
        input  start_valid, pixel_vec, weight_data, Output_syn, result_ready,
        output start_ready, weight_rd_en, weight_addr, WeightPort, PixelPort,
               mac_clear, mac_en, result_valid, result_data, busy
    );

    modport slave (
        output start_valid, pixel_vec, weight_data, Output_syn, result_ready,
        input  start_ready, weight_rd_en, weight_addr, WeightPort, PixelPort,
               mac_clear, mac_en, result_valid, result_data, busy
    );

endinterface

// File: rtl/pixel_weight_sequencer.sv
// Job sequencer feeding a fixed-point multiplier-accumulator with pixel/weight beats.
// Optional macro PIXEL_GATE_EN: zero-pixel beats drop mac_en and zero WeightPort.
module pixel_weight_sequencer
    import nn_mac_pkg::*;
#(
    parameter int N_INPUTS    = 16,
    parameter int WEIGHT_W    = nn_mac_pkg::WEIGHT_W,
    parameter int ACC_W       = nn_mac_pkg::ACC_W,
    parameter int MAC_LATENCY = 2
) (
    input  logic                            clk,
    input  logic                            GlobalReset,
    pixel_weight_sequencer_if.master        bus,
    output seq_state_t                      state_dbg
);

    localparam int ADDR_W  = addr_width(N_INPUTS);
    localparam int DRAIN_W = addr_width(MAC_LATENCY);
    localparam logic [ADDR_W-1:0]  LAST_BEAT  = ADDR_W'(N_INPUTS - 1);
    localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(MAC_LATENCY - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

`ifdef PIXEL_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    seq_state_t          state;
    logic [N_INPUTS-1:0] pixel_sr;
    logic [ADDR_W-1:0]   beat;
    logic [DRAIN_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic [ACC_W-1:0]    result_q;
    logic                start_ready_q;
    logic                busy_q;
    logic                rd_en_q;
    logic                clear_q;
    logic                en_q;
    logic                stream_q;
    logic                pixel_q;
    logic                valid_q;
    logic                pass_weight;

    // Pixels are consumed LSB first from a shift register, so bit k lands on beat k.
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state         <= S_IDLE;
            pixel_sr      <= '0;
            beat          <= '0;
            drain_cnt     <= '0;
            addr_q        <= '0;
            result_q      <= '0;
            start_ready_q <= 1'b1;
            busy_q        <= 1'b0;
            rd_en_q       <= 1'b0;
            clear_q       <= 1'b0;
            en_q          <= 1'b0;
            stream_q      <= 1'b0;
            pixel_q       <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start_valid) begin
                        state         <= S_PRIME;
                        pixel_sr      <= bus.pixel_vec;
                        start_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                        clear_q       <= 1'b1;
                        rd_en_q       <= 1'b1;
                        addr_q        <= '0;
                    end
                end
                S_PRIME: begin
                    state    <= S_STREAM;
                    beat     <= '0;
                    stream_q <= 1'b1;
                    pixel_q  <= pixel_sr[0];
                    en_q     <= pixel_sr[0] | ~GATE;
                    pixel_sr <= pixel_sr >> 1;
                    rd_en_q  <= (N_INPUTS > 1);
                    addr_q   <= (N_INPUTS > 1) ? ADDR_ONE : '0;
                end
                S_STREAM: begin
                    if (beat == LAST_BEAT) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                        stream_q  <= 1'b0;
                        pixel_q   <= 1'b0;
                        en_q      <= 1'b0;
                        rd_en_q   <= 1'b0;
                        addr_q    <= '0;
                    end else begin
                        beat     <= beat + ADDR_ONE;
                        pixel_q  <= pixel_sr[0];
                        en_q     <= pixel_sr[0] | ~GATE;
                        pixel_sr <= pixel_sr >> 1;
                        // The read for beat k+1 is issued during beat k.
                        if ((beat + ADDR_ONE) < LAST_BEAT) begin
                            rd_en_q <= 1'b1;
                            addr_q  <= addr_q + ADDR_ONE;
                        end else begin
                            rd_en_q <= 1'b0;
                            addr_q  <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state    <= S_DONE;
                        result_q <= bus.Output_syn;
                        valid_q  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_ONE;
                    end
                end
                S_DONE: begin
                    if (bus.result_ready) begin
                        state         <= S_IDLE;
                        valid_q       <= 1'b0;
                        busy_q        <= 1'b0;
                        start_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    valid_q       <= 1'b0;
                    busy_q        <= 1'b0;
                    start_ready_q <= 1'b1;
                    stream_q      <= 1'b0;
                    pixel_q       <= 1'b0;
                    en_q          <= 1'b0;
                    rd_en_q       <= 1'b0;
                end
            endcase
        end
    end

    // weight_data arrives in the beat itself, so it is forwarded, not registered.
    assign pass_weight = stream_q & (pixel_q | ~GATE);

    assign bus.start_ready  = start_ready_q;
    assign bus.busy         = busy_q;
    assign bus.weight_rd_en = rd_en_q;
    assign bus.weight_addr  = addr_q;
    assign bus.WeightPort   = pass_weight ? bus.weight_data : '0;
    assign bus.PixelPort    = pixel_q;
    assign bus.mac_clear    = clear_q;
    assign bus.mac_en       = en_q;
    assign bus.result_valid = valid_q;
    assign bus.result_data  = result_q;
    assign state_dbg        = state;

endmodule

// File: tb/tb_pixel_weight_sequencer.sv
// Directed bench for pixel_weight_sequencer with a weight memory and a
// two-cycle-latency behavioural MAC.
module tb_pixel_weight_sequencer;
    import nn_mac_pkg::*;

    localparam int N = 16;
    localparam int L = 2;

    logic       clk = 1'b0;
    logic       GlobalReset;
    seq_state_t state_dbg;

    always #5 clk = ~clk;

    pixel_weight_sequencer_if #(.N_INPUTS(N)) bus ();

    pixel_weight_sequencer #(.N_INPUTS(N), .MAC_LATENCY(L)) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .bus         (bus),
        .state_dbg   (state_dbg)
    );

    // Weight memory: one-cycle read, junk when not read.
    logic [11:0] wmem [N];
    always @(posedge clk) begin
        if (bus.weight_rd_en) bus.weight_data <= wmem[bus.weight_addr];
        else                  bus.weight_data <= 12'($urandom);
    end

    // MAC model: accumulate stage plus one output register.
    logic [18:0] acc, acc_d;
    always @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            acc   <= '0;
            acc_d <= '0;
        end else begin
            if (bus.mac_clear) acc <= '0;
            else if (bus.mac_en && bus.PixelPort)
                acc <= acc + {{7{bus.WeightPort[11]}}, bus.WeightPort};
            acc_d <= acc;
        end
    end
    assign bus.Output_syn = acc_d;

    int checks = 0;
    int passed = 0;

    logic [18:0] r_data;
    int          r_cycle, clear_cnt, clear_at, en_cnt, rd_cnt;
    logic [11:0] wp2;
    logic        pp2;
    bit          timeout;

    task automatic set_weights(input logic [11:0] w0, input logic [11:0] w1, input logic [11:0] rest);
        for (int i = 0; i < N; i++) wmem[i] = rest;
        wmem[0] = w0;
        wmem[1] = w1;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where result_valid rises.
    task automatic run_job(input logic [15:0] pix);
        int cyc;
        clear_cnt = 0; en_cnt = 0; rd_cnt = 0; clear_at = -1; timeout = 0;
        bus.start_valid = 1'b1;
        bus.pixel_vec   = pix;
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.pixel_vec   = 16'($urandom);
        cyc = 1;
        while (!bus.result_valid && cyc < 100) begin
            if (bus.mac_clear) begin clear_cnt++; clear_at = cyc; end
            if (bus.mac_en) en_cnt++;
            if (bus.weight_rd_en) rd_cnt++;
            if (cyc == 2) begin wp2 = bus.WeightPort; pp2 = bus.PixelPort; end
            @(negedge clk);
            cyc++;
        end
        timeout = !bus.result_valid;
        r_cycle = cyc;
        r_data  = bus.result_data;
    endtask

    task automatic finish_result();
        bus.result_ready = 1'b1;
        @(negedge clk);
        bus.result_ready = 1'b0;
    endtask

    task automatic test_reset();
        GlobalReset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b expected 1", bus.start_ready);
        else passed++;
        checks++;
        if ({bus.busy, bus.result_valid, bus.mac_en, bus.mac_clear, bus.weight_rd_en, bus.PixelPort} !== 6'b0)
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.busy, bus.result_valid, bus.mac_en, bus.mac_clear, bus.weight_rd_en, bus.PixelPort});
        else passed++;
        checks++;
        if (bus.WeightPort !== 12'h0 || bus.result_data !== 19'h0 || bus.weight_addr !== 4'h0)
            $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", bus.WeightPort, bus.result_data, bus.weight_addr);
        else passed++;
        GlobalReset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_pixel();
        set_weights(12'h030, 12'h7FF, 12'h7FF);
        run_job(16'h0001);
        checks++;
        if (timeout) $display("FAIL single_timeout: got no result_valid within bound expected valid");
        else passed++;
        checks++;
        if (clear_at !== 1 || clear_cnt !== 1) $display("FAIL single_clear: got cycle %0d count %0d expected cycle 1 count 1", clear_at, clear_cnt);
        else passed++;
        checks++;
        if (wp2 !== 12'h030 || pp2 !== 1'b1) $display("FAIL single_beat0: got %h/%b expected 030/1", wp2, pp2);
        else passed++;
        checks++;
        if (r_cycle !== 20) $display("FAIL single_latency: got %0d expected 20", r_cycle);
        else passed++;
        checks++;
        if (r_data !== 19'h00030) $display("FAIL single_result: got %h expected 00030", r_data);
        else passed++;
        checks++;
        if (rd_cnt !== 16) $display("FAIL single_reads: got %0d expected 16", rd_cnt);
        else passed++;
`ifdef PIXEL_GATE_EN
        checks++;
        if (en_cnt !== 1) $display("FAIL single_en_count: got %0d expected 1", en_cnt);
        else passed++;
`else
        checks++;
        if (en_cnt !== 16) $display("FAIL single_en_count: got %0d expected 16", en_cnt);
        else passed++;
`endif
        finish_result();
        checks++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL single_release: got ready %b valid %b busy %b expected 1/0/0",
                     bus.start_ready, bus.result_valid, bus.busy);
        else passed++;
    endtask

    task automatic test_all_pixels();
        set_weights(12'h030, 12'h030, 12'h030);
        run_job(16'hFFFF);
        checks++;
        if (r_data !== 19'h00300) $display("FAIL all_result: got %h expected 00300", r_data);
        else passed++;
        checks++;
        if (clear_at !== 1 || clear_cnt !== 1) $display("FAIL all_clear: got cycle %0d count %0d expected cycle 1 count 1", clear_at, clear_cnt);
        else passed++;
        checks++;
        if (en_cnt !== 16 || r_cycle !== 20) $display("FAIL all_frame: got en %0d cycle %0d expected 16/20", en_cnt, r_cycle);
        else passed++;
        finish_result();
    endtask

    task automatic test_negative();
        set_weights(12'hFD0, 12'h010, 12'h7FF);
        run_job(16'h0003);
        checks++;
        if (wp2 !== 12'hFD0) $display("FAIL neg_beat0: got %h expected FD0", wp2);
        else passed++;
        checks++;
        if (r_data !== 19'h7FFE0) $display("FAIL neg_result: got %h expected 7FFE0", r_data);
        else passed++;
        finish_result();
    endtask

    task automatic test_zero_pixels();
        set_weights(12'h7FF, 12'h7FF, 12'h7FF);
        run_job(16'h0000);
        checks++;
        if (r_data !== 19'h0) $display("FAIL zero_result: got %h expected 00000", r_data);
        else passed++;
`ifdef PIXEL_GATE_EN
        checks++;
        if (en_cnt !== 0 || wp2 !== 12'h000) $display("FAIL zero_gating: got en %0d wp %h expected 0/000", en_cnt, wp2);
        else passed++;
`else
        checks++;
        if (en_cnt !== 16 || wp2 !== 12'h7FF) $display("FAIL zero_gating: got en %0d wp %h expected 16/7FF", en_cnt, wp2);
        else passed++;
`endif
        checks++;
        if (pp2 !== 1'b0) $display("FAIL zero_pixel: got %b expected 0", pp2);
        else passed++;
        finish_result();
    endtask

    task automatic test_back_to_back();
        logic [18:0] held;
        set_weights(12'h030, 12'h7FF, 12'h7FF);
        run_job(16'h0001);
        held = 19'h00030;
        bus.start_valid = 1'b1;
        bus.pixel_vec   = 16'h0003;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.result_valid !== 1'b1 || bus.result_data !== held || bus.start_ready !== 1'b0)
                $display("FAIL hold_cycle%0d: got valid %b data %h ready %b expected 1/%h/0",
                         i, bus.result_valid, bus.result_data, bus.start_ready, held);
            else passed++;
            @(negedge clk);
        end
        finish_result();
        checks++;
        if (bus.start_ready !== 1'b1 || bus.result_valid !== 1'b0)
            $display("FAIL b2b_release: got ready %b valid %b expected 1/0", bus.start_ready, bus.result_valid);
        else passed++;
        run_job(16'h0003);
        checks++;
        if (clear_at !== 1 || r_cycle !== 20) $display("FAIL b2b_second_timing: got clear %0d valid %0d expected 1/20", clear_at, r_cycle);
        else passed++;
        checks++;
        if (r_data !== 19'h0082F) $display("FAIL b2b_second_result: got %h expected 0082F", r_data);
        else passed++;
        finish_result();
    endtask

    task automatic test_reset_mid_stream();
        bit saw_valid;
        set_weights(12'h030, 12'h030, 12'h030);
        bus.start_valid = 1'b1;
        bus.pixel_vec   = 16'hFFFF;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (7) @(negedge clk);
        #1 GlobalReset = 1'b0;
        #1;
        checks++;
        if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || state_dbg !== S_IDLE)
            $display("FAIL midreset_state: got ready %b busy %b state %0d expected 1/0/0",
                     bus.start_ready, bus.busy, state_dbg);
        else passed++;
        checks++;
        if ({bus.mac_en, bus.weight_rd_en, bus.PixelPort, bus.result_valid} !== 4'b0 || bus.WeightPort !== 12'h0)
            $display("FAIL midreset_outputs: got %b wp %h expected 0000 wp 000",
                     {bus.mac_en, bus.weight_rd_en, bus.PixelPort, bus.result_valid}, bus.WeightPort);
        else passed++;
        @(negedge clk);
        GlobalReset = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.result_valid) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid) $display("FAIL midreset_no_result: got result_valid 1 expected 0");
        else passed++;
        run_job(16'hFFFF);
        checks++;
        if (timeout || r_data !== 19'h00300) $display("FAIL midreset_next_job: got %h expected 00300", r_data);
        else passed++;
        finish_result();
    endtask

    initial begin
        bus.start_valid  = 1'b0;
        bus.pixel_vec    = '0;
        bus.result_ready = 1'b0;
        GlobalReset      = 1'b0;
        for (int i = 0; i < N; i++) wmem[i] = '0;
        test_reset();
        test_single_pixel();
        test_all_pixels();
        test_negative();
        test_zero_pixels();
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000");
        $fatal(1, "bench timeout");
    end

endmodule
